// File: rtl/instruction_fetch_pkg.sv
// Shared fetch-stage types and constants.
// NOP_INSTR_C is also used by decode to build pipeline bubbles.
package instruction_fetch_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    REQ   = 3'd1,
    HOLD  = 3'd2,
    DRAIN = 3'd3,
    FAULT = 3'd4
  } fetch_state_e;

  localparam logic [31:0] NOP_INSTR_C = 32'h0000_0013;

  function automatic logic pc_aligned(input logic [31:0] pc);
    return pc[1:0] == 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding memory read,
// handshake to decode, flush and misaligned-PC fault handling.
module instruction_fetch
  import instruction_fetch_pkg::*;
#(
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_C
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] pc_in,
  output logic        pc_advance,
  input  logic        flush,
  output logic        mem_read,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] instr_out,
  output logic [31:0] instr_pc,
  output logic        misaligned
);

  fetch_state_e state_q;
  logic [31:0]  instr_q;
  logic [31:0]  ipc_q;
  logic         valid_q;
  logic         mis_q;
  logic         aligned;

  assign aligned = pc_aligned(pc_in);

  // Address is taken straight from the PC stage; it cannot
  // move while a request is pending since pc_advance is low.
  assign mem_read   = (state_q == REQ) && aligned;
  assign mem_addr   = mem_read ? pc_in : 32'd0;
  assign pc_advance = (state_q == HOLD) && instr_ready && !flush;

  assign instr_valid = valid_q;
  assign instr_out   = instr_q;
  assign instr_pc    = ipc_q;
  assign misaligned  = mis_q;

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      instr_q <= NOP_INSTR;
      ipc_q   <= 32'd0;
      valid_q <= 1'b0;
      mis_q   <= 1'b0;
    end else begin
      if (flush) begin
        instr_q <= NOP_INSTR;
      end
      unique case (state_q)
        IDLE: begin
          state_q <= REQ;
        end
        REQ: begin
          if (!aligned) begin
            if (!flush) begin
              state_q <= FAULT;
              mis_q   <= 1'b1;
            end
          end else if (flush) begin
            // Without the ack the read is still in flight.
            state_q <= mem_ack ? REQ : DRAIN;
          end else if (mem_ack) begin
            instr_q <= mem_rdata;
            ipc_q   <= pc_in;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (flush || instr_ready) begin
            valid_q <= 1'b0;
            state_q <= REQ;
          end
        end
        DRAIN: begin
          if (mem_ack) begin
            state_q <= REQ;
          end
        end
        FAULT: begin
          if (flush) begin
            mis_q   <= 1'b0;
            state_q <= REQ;
          end
        end
        default: begin
          state_q <= IDLE;
          valid_q <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Directed self-checking bench for instruction_fetch.
// Table of fetch scenarios plus hand-written corner sequences.
module tb_instruction_fetch;

  logic        clock;
  logic        reset;
  logic [31:0] pc_in;
  logic        pc_advance;
  logic        flush;
  logic        mem_read;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [31:0] mem_rdata;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_out;
  logic [31:0] instr_pc;
  logic        misaligned;

  int errors = 0;
  int checks = 0;

  logic        pc_set;
  logic [31:0] pc_set_val;
  logic        auto_mem;
  logic        man_ack;
  logic [31:0] man_rdata;
  int          lat;
  int          cnt;
  logic        auto_ack;

  instruction_fetch dut (
    .clock       (clock),
    .reset       (reset),
    .pc_in       (pc_in),
    .pc_advance  (pc_advance),
    .flush       (flush),
    .mem_read    (mem_read),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .instr_valid (instr_valid),
    .instr_ready (instr_ready),
    .instr_out   (instr_out),
    .instr_pc    (instr_pc),
    .misaligned  (misaligned)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // PC stage model
  always @(posedge clock) begin
    if (pc_set) pc_in <= pc_set_val;
    else if (pc_advance) pc_in <= pc_in + 32'd4;
  end

  // Memory model: ack on the lat-th cycle of mem_read
  assign auto_ack  = mem_read && (cnt >= lat - 1);
  assign mem_ack   = auto_mem ? auto_ack : man_ack;
  assign mem_rdata = auto_mem ? (32'h0050_0093 + mem_addr) : man_rdata;

  always @(posedge clock) begin
    if (!mem_read || auto_ack) cnt <= 0;
    else cnt <= cnt + 1;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic do_reset(input logic [31:0] pc);
    reset = 1'b1;
    flush = 1'b0;
    pc_set = 1'b1;
    pc_set_val = pc;
    @(posedge clock);
    @(posedge clock);
    @(negedge clock);
    reset = 1'b0;
    pc_set = 1'b0;
  endtask

  typedef struct {
    logic [31:0] pc;
    int          lat;
    int          exp_cyc;
    logic [31:0] exp_instr;
    int          exp_gap;
  } vec_t;

  vec_t vecs[3];

  initial begin
    int c;
    int reads;
    int bad_addr;
    int pulses;
    logic seen_bad;
    logic [31:0] p;

    reset = 1'b1;
    flush = 1'b0;
    instr_ready = 1'b1;
    pc_set = 1'b1;
    pc_set_val = 32'd0;
    pc_in = 32'd0;
    auto_mem = 1'b1;
    man_ack = 1'b0;
    man_rdata = 32'd0;
    lat = 1;

    vecs[0] = '{32'h0000_0000, 1, 3, 32'h0050_0093, 2};
    vecs[1] = '{32'h0000_0040, 3, 5, 32'h0050_00d3, 4};
    vecs[2] = '{32'h0000_1000, 2, 4, 32'h0050_1093, 3};

    // Reset state
    @(posedge clock);
    @(negedge clock);
    chk("rst_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_read", {31'd0, mem_read}, 32'd0);
    chk("rst_addr", mem_addr, 32'd0);
    chk("rst_instr", instr_out, 32'h0000_0013);
    chk("rst_ipc", instr_pc, 32'd0);
    chk("rst_flags", {30'd0, pc_advance, misaligned}, 32'd0);

    // Table of fetch scenarios
    for (int i = 0; i < 3; i++) begin
      auto_mem = 1'b1;
      lat = vecs[i].lat;
      instr_ready = 1'b1;
      do_reset(vecs[i].pc);
      c = 1;
      reads = 0;
      bad_addr = 0;
      while (!instr_valid && c < 20) begin
        if (mem_read) begin
          reads++;
          if (mem_addr !== vecs[i].pc) bad_addr++;
        end
        cyc();
        c++;
      end
      chk($sformatf("v%0d_cycle", i), c, vecs[i].exp_cyc);
      chk($sformatf("v%0d_instr", i), instr_out, vecs[i].exp_instr);
      chk($sformatf("v%0d_ipc", i), instr_pc, vecs[i].pc);
      chk($sformatf("v%0d_reads", i), reads, vecs[i].lat);
      chk($sformatf("v%0d_addr_stable", i), bad_addr, 0);
      chk($sformatf("v%0d_adv", i), {31'd0, pc_advance}, 32'd1);
      pulses = 0;
      c = 0;
      do begin
        if (pc_advance) pulses++;
        cyc();
        c++;
      end while (!instr_valid && c < 20);
      chk($sformatf("v%0d_gap", i), c, vecs[i].exp_gap);
      chk($sformatf("v%0d_pulses", i), pulses, 1);
      chk($sformatf("v%0d_pc_next", i), pc_in, vecs[i].pc + 32'd4);
      chk($sformatf("v%0d_ipc_next", i), instr_pc, vecs[i].pc + 32'd4);
    end

    // Decode stall in HOLD
    lat = 1;
    instr_ready = 1'b0;
    do_reset(32'h0000_0200);
    c = 0;
    while (!instr_valid && c < 20) begin
      cyc();
      c++;
    end
    chk("stall_reach", {31'd0, instr_valid}, 32'd1);
    for (int k = 0; k < 5; k++) begin
      chk($sformatf("stall_hold%0d", k),
          {instr_valid, pc_advance, instr_out[29:0]},
          {1'b1, 1'b0, 30'h0050_0293});
      cyc();
    end
    instr_ready = 1'b1;
    #1;
    chk("stall_release_adv", {31'd0, pc_advance}, 32'd1);
    cyc();
    chk("stall_one_pulse", {31'd0, pc_advance}, 32'd0);
    chk("stall_pc", pc_in, 32'h0000_0204);

    // Flush with request outstanding -> drain
    auto_mem = 1'b0;
    man_ack = 1'b0;
    do_reset(32'h0000_0300);
    cyc();
    chk("drain_req", {31'd0, mem_read}, 32'd1);
    flush = 1'b1;
    pc_set = 1'b1;
    pc_set_val = 32'h0000_0400;
    cyc();
    flush = 1'b0;
    pc_set = 1'b0;
    chk("drain_idle_bus", {30'd0, mem_read, instr_valid}, 32'd0);
    man_ack = 1'b1;
    man_rdata = 32'hdead_beef;
    #1;
    chk("drain_no_read", {31'd0, mem_read}, 32'd0);
    cyc();
    man_ack = 1'b0;
    chk("drain_refetch", {mem_read, mem_addr[30:0]}, {1'b1, 31'h400});
    chk("drain_discard", instr_out, 32'h0000_0013);
    man_ack = 1'b1;
    man_rdata = 32'h1111_1111;
    cyc();
    man_ack = 1'b0;
    chk("drain_new_instr", instr_out, 32'h1111_1111);
    chk("drain_new_pc", {instr_valid, instr_pc[30:0]}, {1'b1, 31'h400});

    // Misaligned PC fault
    auto_mem = 1'b1;
    lat = 1;
    do_reset(32'h0000_0102);
    seen_bad = 1'b0;
    for (int k = 0; k < 6; k++) begin
      if (mem_read) seen_bad = 1'b1;
      cyc();
    end
    chk("mis_no_read", {31'd0, seen_bad}, 32'd0);
    chk("mis_sticky", {30'd0, misaligned, instr_valid}, 32'd2);
    flush = 1'b1;
    pc_set = 1'b1;
    pc_set_val = 32'h0000_0100;
    cyc();
    flush = 1'b0;
    pc_set = 1'b0;
    chk("mis_cleared", {31'd0, misaligned}, 32'd0);
    chk("mis_refetch", {mem_read, mem_addr[30:0]}, {1'b1, 31'h100});
    cyc();
    chk("mis_fetch", instr_out, 32'h0050_0193);

    // Flush and ready together in HOLD
    lat = 1;
    instr_ready = 1'b0;
    do_reset(32'h0000_0000);
    cyc();
    cyc();
    chk("fh_hold", {31'd0, instr_valid}, 32'd1);
    instr_ready = 1'b1;
    flush = 1'b1;
    #1;
    chk("fh_no_adv", {31'd0, pc_advance}, 32'd0);
    p = pc_in;
    cyc();
    flush = 1'b0;
    chk("fh_nop", instr_out, 32'h0000_0013);
    chk("fh_invalid", {31'd0, instr_valid}, 32'd0);
    chk("fh_pc_kept", pc_in, p);

    // Reset overrides outstanding request, flush and ack
    auto_mem = 1'b0;
    man_ack = 1'b0;
    do_reset(32'h0000_0500);
    cyc();
    chk("ro_req", {31'd0, mem_read}, 32'd1);
    reset = 1'b1;
    flush = 1'b1;
    man_ack = 1'b1;
    man_rdata = 32'hcafe_f00d;
    cyc();
    reset = 1'b0;
    flush = 1'b0;
    man_ack = 1'b0;
    chk("ro_idle", {30'd0, mem_read, instr_valid}, 32'd0);
    chk("ro_instr", instr_out, 32'h0000_0013);
    cyc();
    chk("ro_no_drain", {mem_read, mem_addr[30:0]}, {1'b1, 31'h500});

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
